// File: rtl/saes_pkg.sv
// Shared types and GF(2^4) helpers for the S-AES decryption slice.
// SAES_DEC_CNT_EN is not used here; see saes_dec_core.
package saes_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RND1 = 2'd1,
      S_RND0 = 2'd2,
      S_HOLD = 2'd3
   } state_e;

   // Inverse S-box, entry i held in bits [4*i +: 4].
   localparam logic [63:0] INV_SBOX = 64'hED4C_3206_F871_B95A;

   function automatic logic [3:0] gf_mul2(input logic [3:0] a);
      return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
   endfunction

   function automatic logic [3:0] gf_mul9(input logic [3:0] a);
      return gf_mul2(gf_mul2(gf_mul2(a))) ^ a;
   endfunction

   function automatic logic [15:0] inv_shift_rows(input logic [15:0] s);
      return {s[15:12], s[3:0], s[7:4], s[11:8]};
   endfunction

   function automatic logic [3:0] inv_sbox(input logic [3:0] n);
      return INV_SBOX[{n, 2'b00} +: 4];
   endfunction

   function automatic logic [15:0] inv_sub_nib(input logic [15:0] s);
      return {inv_sbox(s[15:12]), inv_sbox(s[11:8]),
              inv_sbox(s[7:4]), inv_sbox(s[3:0])};
   endfunction

endpackage

// File: rtl/saes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubNib, AddRoundKey,
// then InvMixColumns when mix_en is set.
module saes_inv_round
   import saes_pkg::*;
(
   input  logic [15:0] st,
   input  logic [15:0] key,
   input  logic        mix_en,
   output logic [15:0] nxt
);

   logic [15:0] t;
   logic [15:0] mixed;

   always_comb begin
      t = inv_sub_nib(inv_shift_rows(st)) ^ key;
      mixed = {gf_mul9(t[15:12]) ^ gf_mul2(t[11:8]),
               gf_mul2(t[15:12]) ^ gf_mul9(t[11:8]),
               gf_mul9(t[7:4])   ^ gf_mul2(t[3:0]),
               gf_mul2(t[7:4])   ^ gf_mul9(t[3:0])};
      nxt = mix_en ? mixed : t;
   end

endmodule

// File: rtl/saes_dec_core.sv
// Iterative S-AES decryption core, one round per clock, valid/ready both sides.
// Define SAES_DEC_CNT_EN to add the saturating blk_cnt output.
module saes_dec_core
   import saes_pkg::*;
`ifdef SAES_DEC_CNT_EN
#(
   parameter int unsigned CNT_W = 16
)
`endif
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] ct,
   input  logic [15:0] key0,
   input  logic [15:0] key1,
   input  logic [15:0] key2,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] pt
`ifdef SAES_DEC_CNT_EN
   ,
   output logic [CNT_W-1:0] blk_cnt
`endif
);

   state_e      state_q, state_d;
   logic [15:0] st_q, st_d;
   logic [15:0] k1_q, k1_d;
   logic [15:0] k0_q, k0_d;
   logic [15:0] pt_q, pt_d;
   logic        ov_q, ov_d;
   logic [15:0] rnd_out;
   logic        in_rnd1;

   assign in_rnd1 = (state_q == S_RND1);

   saes_inv_round u_round (
      .st     (st_q),
      .key    (in_rnd1 ? k1_q : k0_q),
      .mix_en (in_rnd1),
      .nxt    (rnd_out)
   );

   always_comb begin
      state_d = state_q;
      st_d    = st_q;
      k1_d    = k1_q;
      k0_d    = k0_q;
      pt_d    = pt_q;
      ov_d    = ov_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               st_d    = ct ^ key2;
               k1_d    = key1;
               k0_d    = key0;
               state_d = S_RND1;
            end
         end
         S_RND1: begin
            st_d    = rnd_out;
            state_d = S_RND0;
         end
         S_RND0: begin
            pt_d    = rnd_out;
            ov_d    = 1'b1;
            state_d = S_HOLD;
         end
         S_HOLD: begin
            if (out_ready) begin
               ov_d    = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         st_q    <= '0;
         k1_q    <= '0;
         k0_q    <= '0;
         pt_q    <= '0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         st_q    <= st_d;
         k1_q    <= k1_d;
         k0_q    <= k0_d;
         pt_q    <= pt_d;
         ov_q    <= ov_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = ov_q;
   assign pt        = pt_q;

`ifdef SAES_DEC_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturate rather than wrap so a long run never reads as a small count.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == S_HOLD && out_ready && cnt_q != '1)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign blk_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_saes_dec_core.sv
// Self-checking bench for saes_dec_core: known answers, protocol corners,
// and random blocks checked by round-tripping through an S-AES encrypt model.
module tb_saes_dec_core;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] ct, key0, key1, key2;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] pt;
`ifdef SAES_DEC_CNT_EN
   logic [1:0]  blk_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

`ifdef SAES_DEC_CNT_EN
   saes_dec_core #(.CNT_W(2)) dut (
`else
   saes_dec_core dut (
`endif
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ct        (ct),
      .key0      (key0),
      .key1      (key1),
      .key2      (key2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pt        (pt)
`ifdef SAES_DEC_CNT_EN
      ,
      .blk_cnt   (blk_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---- reference: textbook S-AES encryption and key schedule ----
   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [63:0] t;
      t = 64'h7FEC_3026_581D_BA49;
      return t[4*x +: 4];
   endfunction

   function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] r;
      logic [3:0] aa;
      r  = 4'h0;
      aa = a;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) r = r ^ aa;
         aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
      end
      return r;
   endfunction

   function automatic logic [15:0] sub16(input logic [15:0] s);
      return {sbox(s[15:12]), sbox(s[11:8]), sbox(s[7:4]), sbox(s[3:0])};
   endfunction

   function automatic logic [15:0] shr(input logic [15:0] s);
      return {s[15:12], s[3:0], s[7:4], s[11:8]};
   endfunction

   function automatic logic [15:0] mix(input logic [15:0] s);
      return {s[15:12] ^ gmul(4'h4, s[11:8]), gmul(4'h4, s[15:12]) ^ s[11:8],
              s[7:4] ^ gmul(4'h4, s[3:0]),    gmul(4'h4, s[7:4]) ^ s[3:0]};
   endfunction

   task automatic key_exp(input logic [15:0] k, output logic [15:0] k1,
                          output logic [15:0] k2);
      logic [7:0] w0, w1, w2, w3, w4, w5;
      w0 = k[15:8];
      w1 = k[7:0];
      w2 = w0 ^ 8'h80 ^ {sbox(w1[3:0]), sbox(w1[7:4])};
      w3 = w2 ^ w1;
      w4 = w2 ^ 8'h30 ^ {sbox(w3[3:0]), sbox(w3[7:4])};
      w5 = w4 ^ w3;
      k1 = {w2, w3};
      k2 = {w4, w5};
   endtask

   function automatic logic [15:0] encrypt(input logic [15:0] p,
      input logic [15:0] k0, input logic [15:0] k1, input logic [15:0] k2);
      logic [15:0] s;
      s = p ^ k0;
      s = mix(shr(sub16(s))) ^ k1;
      s = shr(sub16(s)) ^ k2;
      return s;
   endfunction

   // Accept one block, scramble the inputs right after the accept edge,
   // then check latency, result and the output handshake.
   task automatic run_block(input string tag, input logic [15:0] c,
      input logic [15:0] k0, input logic [15:0] k1, input logic [15:0] k2,
      input logic [15:0] exp);
      int cyc;
      out_ready = 1'b1;
      cyc = 0;
      while (!in_ready && cyc < 20) begin
         step();
         cyc++;
      end
      chk({tag, "_rdy"}, in_ready, 1'b1);
      ct = c; key0 = k0; key1 = k1; key2 = k2;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      ct = 16'hFFFF; key0 = 16'hFFFF; key1 = 16'hFFFF; key2 = 16'hFFFF;
      cyc = 1;
      while (!out_valid && cyc < 20) begin
         step();
         cyc++;
      end
      chk({tag, "_lat"}, cyc, 3);
      chk({tag, "_pt"}, pt, exp);
      step();
      chk({tag, "_done"}, out_valid, 1'b0);
   endtask

   initial begin
      logic [15:0] rk, rk1, rk2, rp, rc, hold_pt;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      ct = '0; key0 = '0; key1 = '0; key2 = '0;
      step();
      step();
      chk("rst_ov", out_valid, 1'b0);
      chk("rst_pt", pt, 16'h0);
      chk("rst_ir", in_ready, 1'b1);
`ifdef SAES_DEC_CNT_EN
      chk("rst_cnt", blk_cnt, 2'd0);
`endif
      rst = 1'b0;
      step();
      chk("idle_ir", in_ready, 1'b1);

      run_block("ka1", 16'h24EC, 16'h4AF5, 16'hDD28, 16'h87AF, 16'hD728);
      key_exp(16'hA73B, rk1, rk2);
      run_block("ka2", 16'h0738, 16'hA73B, rk1, rk2, 16'h6F6B);

      // Backpressure with a stray in_valid pulse while holding.
      out_ready = 1'b0;
      ct = 16'h24EC; key0 = 16'h4AF5; key1 = 16'hDD28; key2 = 16'h87AF;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      chk("bp_ov", out_valid, 1'b1);
      hold_pt = 16'hD728;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_pt%0d", i), pt, hold_pt);
         chk($sformatf("bp_ir%0d", i), in_ready, 1'b0);
         chk($sformatf("bp_ov%0d", i), out_valid, 1'b1);
         in_valid = (i == 2);
         ct = 16'h1234;
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      chk("bp_rel_ov", out_valid, 1'b0);
      chk("bp_rel_ir", in_ready, 1'b1);
      chk("bp_rel_pt", pt, hold_pt);

      // Reset while in RND1.
      ct = 16'h24EC; key0 = 16'h4AF5; key1 = 16'hDD28; key2 = 16'h87AF;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("mid_ir", in_ready, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_ov", out_valid, 1'b0);
      chk("mid_pt", pt, 16'h0);
      chk("mid_ir1", in_ready, 1'b1);
      step();
      chk("mid_ov1", out_valid, 1'b0);
      run_block("post_rst", 16'h0738, 16'hA73B, rk1, rk2, 16'h6F6B);

      // Random keys and plaintexts, round-tripped through the encrypt model.
      for (int i = 0; i < 24; i++) begin
         rk = 16'($urandom);
         rp = 16'($urandom);
         key_exp(rk, rk1, rk2);
         rc = encrypt(rp, rk, rk1, rk2);
         run_block($sformatf("rnd%0d", i), rc, rk, rk1, rk2, rp);
      end

`ifdef SAES_DEC_CNT_EN
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("cnt_clr0", blk_cnt, 2'd0);
      out_ready = 1'b1;
      ct = 16'h24EC; key0 = 16'h4AF5; key1 = 16'hDD28; key2 = 16'h87AF;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         step();
         step();
         chk($sformatf("cnt_pt%0d", i), pt, 16'hD728);
         step();
         chk($sformatf("cnt%0d", i), blk_cnt, (i < 2) ? i + 1 : 3);
      end
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("cnt_clr", blk_cnt, 2'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/saes_dec_core.md
Name: saes_dec_core

Overview:
- Iterative S-AES decryption engine, directly downstream of the key-expansion stage.
- Consumes its three 16-bit round keys (key0, key1, key2) together with a 16-bit ciphertext and produces the 16-bit plaintext.
- One round per clock.
- Valid/ready on both input and output sides so it can sit between a ciphertext source and a plaintext sink.

Parameters:
- CNT_W, 16: width of the completed-block counter. Used only when SAES_DEC_CNT_EN is defined.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ciphertext and round keys valid
- in_ready  out  1  core can accept a block
- ct  in  16  ciphertext
- key0  in  16  round key 0 (original key)
- key1  in  16  round key 1
- key2  in  16  round key 2
- out_valid  out  1  plaintext valid
- out_ready  in  1  sink accepts plaintext
- pt  out  16  plaintext
- blk_cnt  out  CNT_W  completed-block count; present only with SAES_DEC_CNT_EN

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Nibble layout: s = {n0,n1,n2,n3}, n0 = s[15:12]. Columns are (n0,n1) and (n2,n3).
- InvShiftRows: swap n1 and n3.
- InvSubNib: per-nibble inverse S-box, 0..F -> A,5,9,B,1,7,8,F,6,0,2,3,C,4,D,E.
- InvMixColumns, per column, over GF(2^4) mod x^4+x+1:
  - a' = 9a ^ 2b
  - b' = 2a ^ 9b
- FSM states: IDLE, RND1, RND0, HOLD.
- IDLE:
  - in_ready = 1.
  - On in_valid: st <= ct ^ key2; latch key1 and key0 into internal registers; go to RND1.
- RND1: st <= InvMix(InvSub(InvShift(st)) ^ k1); go to RND0.
- RND0: pt <= InvSub(InvShift(st)) ^ k0; out_valid <= 1; go to HOLD.
- HOLD:
  - pt and out_valid held stable.
  - On out_ready: out_valid <= 0; go to IDLE.
- in_ready is 1 only in IDLE. It is combinational from state, with no dependency on in_valid.
- Latency: accept edge at cycle t gives out_valid = 1 from cycle t+3.
- Throughput: at most one block per 4 cycles when out_ready is held 1.
- Key handling:
  - Key inputs and ct are sampled only at the accept edge.
  - Changes afterwards do not affect the block in flight.
- in_valid asserted outside IDLE is ignored; no accept occurs.
- Reset (any state, including mid-round or in HOLD):
  - next edge: state = IDLE, out_valid = 0, pt = 0, internal st and latched keys = 0, blk_cnt = 0.
  - in_ready = 1 in the cycle after reset deasserts.
- rst has priority over in_valid and out_ready in the same cycle.
- GF multiply results are 4-bit. No carries escape the nibble.

Optional Feature:
- Macro: SAES_DEC_CNT_EN.
- Defined:
  - blk_cnt port exists.
  - Increments by 1 on each output handshake (HOLD and out_ready).
  - Saturates at all-ones; no wrap.
  - Cleared by rst.
- Undefined:
  - blk_cnt port and counter absent.
  - All other behaviour identical.

Decomposition:
- Shared package saes_pkg holds:
  - FSM state enum
  - inverse S-box constant table
  - GF(2^4) multiply-by-2 and multiply-by-9 functions
  - nibble-swap/InvShiftRows function
- One natural sub-module: saes_inv_round. It is combinational (state, key, mix_en) -> next state and is shared by RND1 (mix_en = 1) and RND0 (mix_en = 0).

Test Plan:
- Known answer 1: key 0x4AF5 (key0=0x4AF5, key1=0xDD28, key2=0x87AF), ct 0x24EC -> pt 0xD728, out_valid exactly 3 cycles after accept.
- Known answer 2: key 0xA73B with its expanded key1/key2, ct 0x0738 -> pt 0x6F6B.
- Backpressure: out_ready = 0 for 5 cycles after out_valid -> pt stable, in_ready = 0 throughout; in_valid pulsed meanwhile is not accepted; out_ready = 1 -> IDLE next cycle.
- Input stability: change ct and keys to 0xFFFF the cycle after accept -> result still equals the known answer 1 value.
- Reset mid-operation: assert rst in RND1 -> next cycle IDLE, out_valid = 0, pt = 0; a subsequent block decrypts correctly.
- Counter (with SAES_DEC_CNT_EN, CNT_W = 2): 5 back-to-back blocks -> blk_cnt 1, 2, 3, 3, 3; rst -> 0.
